// File: rtl/gray_conv_arbiter_pkg.sv
// Shared types and defaults for the Gray-to-binary converter arbiter.
// Optional out_parity output is enabled by defining GCA_PARITY_EN.
package gray_conv_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 4;

  // Index width that never collapses to zero bits.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gray_conv_arbiter_if.sv
// Request/result bus of gray_conv_arbiter; slave is the DUT view, master the driver view.
// out_parity exists only when GCA_PARITY_EN is defined.
interface gray_conv_arbiter_if
  import gray_conv_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) ();

  localparam int IDW = id_width(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_gray;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [W-1:0]      out_binary;
  logic [IDW-1:0]    out_id;
  logic              out_ready;
`ifdef GCA_PARITY_EN
  logic              out_parity;
`endif

`ifdef GCA_PARITY_EN
  modport slave  (input  req_valid, req_gray, out_ready,
                  output req_ready, out_valid, out_binary, out_id, out_parity);
  modport master (output req_valid, req_gray, out_ready,
                  input  req_ready, out_valid, out_binary, out_id, out_parity);
`else
  modport slave  (input  req_valid, req_gray, out_ready,
                  output req_ready, out_valid, out_binary, out_id);
  modport master (output req_valid, req_gray, out_ready,
                  input  req_ready, out_valid, out_binary, out_id);
`endif

endinterface

// File: rtl/gray_conv_arbiter_rr_arbiter.sv
// Round-robin grant: first requester found searching upward from ptr_i+1, with wrap.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o
);

  int idx;

  // Walk from the farthest offset down so the nearest requester is written last.
  always_comb begin
    grant_o = '0;
    idx     = 0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = (int'(ptr_i) + off) % NREQ;
      if (req_i[IDW'(idx)]) begin
        grant_o             = '0;
        grant_o[IDW'(idx)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// NREQ requesters share one Gray-to-binary converter through a round-robin arbiter.
// Define GCA_PARITY_EN to add the registered out_parity output.
module gray_conv_arbiter
  import gray_conv_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input logic                clk,
  input logic                rst,
  gray_conv_arbiter_if.slave bus
);

  localparam int IDW = id_width(NREQ);

  state_t          state_q;
  logic            out_valid_q;
  logic [W-1:0]    out_binary_q;
  logic [IDW-1:0]  out_id_q;
  logic [IDW-1:0]  ptr_q;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] req_ready_d;
  logic [W-1:0]    win_gray;
  logic [W-1:0]    bin_d;
  logic [IDW-1:0]  win_id_d;
  logic            accept;
  logic            fire;
`ifdef GCA_PARITY_EN
  logic            out_parity_q;
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  always_comb begin
    win_gray = '0;
    win_id_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_gray = bus.req_gray[i*W +: W];
        win_id_d = IDW'(i);
      end
    end
  end

  // Each binary bit is the XOR of the Gray bits at and above it.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_conv
      assign bin_d[gi] = ^win_gray[W-1:gi];
    end
  endgenerate

  // A full BUSY slot frees up in the same cycle downstream takes it.
  assign accept      = (state_q == IDLE) || bus.out_ready;
  assign req_ready_d = (accept && !rst) ? grant : '0;
  assign fire        = |req_ready_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_binary_q <= '0;
      out_id_q     <= '0;
      ptr_q        <= IDW'(NREQ - 1);
`ifdef GCA_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else begin
      if (fire) begin
        state_q      <= BUSY;
        out_valid_q  <= 1'b1;
        out_binary_q <= bin_d;
        out_id_q     <= win_id_d;
        ptr_q        <= win_id_d;
`ifdef GCA_PARITY_EN
        out_parity_q <= ^bin_d;
`endif
      end else if (state_q == BUSY && bus.out_ready) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = req_ready_d;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_binary = out_binary_q;
  assign bus.out_id     = out_id_q;
`ifdef GCA_PARITY_EN
  assign bus.out_parity = out_parity_q;
`endif

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing the converter; legal range 2..8.
REQ-002 Parameter: W, 4, Gray/binary word width in bits.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: req_valid  input  NREQ  per-requester request strobe.
REQ-006 Port: req_gray  input  NREQ*W  packed Gray words; requester i uses bits [i*W +: W].
REQ-007 Port: req_ready  output  NREQ  one-hot (or zero) grant/accept indication.
REQ-008 Port: out_valid  output  1  converted result available.
REQ-009 Port: out_binary  output  W  converted binary word.
REQ-010 Port: out_id  output  clog2(NREQ)  index of the requester that owns out_binary.
REQ-011 Port: out_ready  input  1  downstream accepts the result when high with out_valid.

Function
REQ-012 The block SHALL share one combinational W-bit Gray-to-binary converter (b[W-1]=g[W-1]; b[k]=b[k+1]^g[k]) among NREQ requesters.
REQ-013 FSM states SHALL be IDLE (no result held) and BUSY (result held, out_valid=1).
REQ-014 Accept condition SHALL be: state==IDLE, or state==BUSY and out_ready==1.
REQ-015 When accept holds and any req_valid is high, exactly one req_ready bit SHALL be high in that same cycle, for the round-robin winner; otherwise req_ready SHALL be all zero.
REQ-016 Round-robin SHALL search from index ptr+1 upward with wrap-around modulo NREQ; ptr SHALL update to the winner on each accepted transfer only.
REQ-017 On accept, the converted winner word and winner index SHALL be registered; out_valid SHALL rise the next cycle (latency 1 clock).
REQ-018 BUSY with out_ready=1 and no pending request SHALL go to IDLE with out_valid=0 next cycle; with a pending request it SHALL stay BUSY with the new result (full throughput, one result per clock).
REQ-019 BUSY with out_ready=0 SHALL hold out_binary, out_id and out_valid stable and keep req_ready all zero.
REQ-020 Requesters SHALL hold req_valid and req_gray stable until req_ready; a req_valid drop before grant SHALL be legal and SHALL simply not be granted.
REQ-021 No requester with req_valid held continuously SHALL wait more than NREQ-1 accepts.

Reset
REQ-022 On rst: state=IDLE, out_valid=0, out_binary=0, out_id=0, ptr=NREQ-1 (requester 0 has first priority), req_ready=0 while rst is high.
REQ-023 Reset asserted mid-BUSY SHALL discard the held result immediately; no handshake completes during reset.

Configuration
REQ-024 Macro GCA_PARITY_EN defined: additional output out_parity (1 bit) SHALL equal XOR of all bits of out_binary, registered with it, reset 0.
REQ-025 Macro GCA_PARITY_EN undefined: out_parity port SHALL not exist; all other behaviour identical.

Structure
REQ-026 A shared package SHALL hold the FSM state typedef (IDLE, BUSY) and the default constants for NREQ and W.
REQ-027 The round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot grant); the converter SHALL be an inline function or generate loop.

Verification
REQ-028 Single request: req0 gray 4'b1011 -> req_ready[0]=1 same cycle; next cycle out_valid=1, out_binary=4'b1101, out_id=0.
REQ-029 All four valid continuously after reset, out_ready=1 (gray 1000/0110/0001/1111) -> out_id 0,1,2,3 on consecutive cycles; out_binary 1111,0100,0001,1010.
REQ-030 Backpressure: out_ready=0 for 3 cycles while BUSY with req1 pending -> outputs held, req_ready=0; on out_ready=1 req1 granted that cycle.
REQ-031 Fairness: req0 and req2 always valid -> grants alternate 0,2,0,2; no grant gap exceeds NREQ-1.
REQ-032 Reset asserted mid-BUSY -> out_valid=0 and out_binary=0 asynchronously; first grant after release goes to req0.
REQ-033 With GCA_PARITY_EN: result 4'b1101 -> out_parity=1; result 4'b0000 -> out_parity=0.
